// File: rtl/axi_read_scheduler.sv
// axi_read_scheduler: single-outstanding AXI read arbiter for the core's
// read masters (icache, dcache, stream buffer) with aging-based promotion.
module axi_read_scheduler #(
    parameter int N_MASTERS    = 3,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_MASTERS-1:0]            m_arvalid,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_araddr,
    input  logic [N_MASTERS*4-1:0]          m_arlen,
    output logic [N_MASTERS-1:0]            m_arready,
    output logic [N_MASTERS-1:0]            m_rvalid,
    output logic                            m_rlast,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    input  logic [N_MASTERS-1:0]            m_rready,
    output logic                            ARVALID,
    input  logic                            ARREADY,
    output logic [3:0]                      ARID,
    output logic [3:0]                      ARLEN,
    output logic [ADDR_WIDTH-1:0]           ARADDR,
    input  logic                            RVALID,
    output logic                            RREADY,
    input  logic                            RLAST,
    input  logic [3:0]                      RID,
    input  logic [DATA_WIDTH-1:0]           RDATA,
    output logic                            busy,
    output logic [1:0]                      owner,
    output logic                            err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [3:0]              len_q;
    logic [3:0]              owner_q;
    logic [3:0]              beat_q;
    logic                    err_q;
    logic [7:0]              age_q [N_MASTERS];

    logic                    starve_hit;
    logic [3:0]              win;
    logic [N_MASTERS-1:0]    win_oh;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [3:0]              sel_len;
    logic [N_MASTERS-1:0]    own_oh;
    logic                    own_rready;
    logic                    grant;
    logic                    ar_done;
    logic                    beat_acc;
    logic                    err_evt;
    logic [N_MASTERS-1:0]    accept_oh;

    // Winner: lowest-index starved master, else fixed order 1 > 0 > 2 > 3 ...
    always_comb begin
        starve_hit = 1'b0;
        win        = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_arvalid[i] && age_q[i] >= 8'(STARVE_LIMIT)) begin
                starve_hit = 1'b1;
                win        = 4'(i);
            end
        end
        if (!starve_hit) begin
            for (int i = N_MASTERS - 1; i >= 2; i--) begin
                if (m_arvalid[i]) win = 4'(i);
            end
            if (m_arvalid[0]) win = 4'd0;
            if (N_MASTERS > 1 && m_arvalid[1]) win = 4'd1;
        end
    end

    // One-hot decode of winner and owner, plus request-field mux
    always_comb begin
        win_oh     = '0;
        own_oh     = '0;
        sel_addr   = '0;
        sel_len    = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (win == 4'(i)) begin
                win_oh[i] = 1'b1;
                sel_addr  = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len   = m_arlen[i*4 +: 4];
            end
            if (owner_q == 4'(i)) own_oh[i] = 1'b1;
        end
        own_rready = |(m_rready & own_oh);
    end

    // Next-state and channel steering
    always_comb begin
        state_d   = state_q;
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = 1'b0;
        m_rdata   = '0;
        ARVALID   = 1'b0;
        ARADDR    = '0;
        ARLEN     = '0;
        ARID      = '0;
        RREADY    = 1'b0;
        grant     = 1'b0;
        ar_done   = 1'b0;
        beat_acc  = 1'b0;
        err_evt   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (RVALID) err_evt = 1'b1;
                if (|m_arvalid) begin
                    grant     = 1'b1;
                    m_arready = win_oh;
                    state_d   = S_ADDR;
                end
            end
            S_ADDR: begin
                ARVALID = 1'b1;
                ARADDR  = addr_q;
                ARLEN   = len_q;
                ARID    = owner_q;
                if (RVALID) err_evt = 1'b1;
                if (ARREADY) begin
                    ar_done = 1'b1;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                m_rdata = RDATA;
                if (RVALID && RID != owner_q) begin
                    // Stray beat: consume it so the slave is not wedged
                    RREADY  = 1'b1;
                    err_evt = 1'b1;
                end else if (RVALID) begin
                    m_rvalid = own_oh;
                    m_rlast  = RLAST;
                    RREADY   = own_rready;
                    beat_acc = own_rready;
                end
                if (beat_acc) begin
                    if (RLAST) begin
                        state_d = S_IDLE;
                        if (beat_q != len_q) err_evt = 1'b1;
                    end else if (beat_q == len_q) begin
                        err_evt = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign accept_oh = grant ? win_oh : '0;
    assign busy      = (state_q != S_IDLE);
    assign owner     = owner_q[1:0];
    assign err       = err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Latched request, beat counter and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            owner_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (grant) begin
                addr_q  <= sel_addr;
                len_q   <= sel_len;
                owner_q <= win;
            end
            if (ar_done)       beat_q <= '0;
            else if (beat_acc) beat_q <= beat_q + 4'd1;
            if (err_evt) err_q <= 1'b1;
        end
    end

    // Per-master waiting age, saturating, cleared on accept or withdrawal
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_MASTERS; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!m_arvalid[i] || accept_oh[i]) age_q[i] <= '0;
                else if (age_q[i] != 8'hff)        age_q[i] <= age_q[i] + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_scheduler.sv
// tb_axi_read_scheduler: directed and randomized checks of the read
// scheduler against a transaction-level arbitration/aging model.
module tb_axi_read_scheduler;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 8;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  m_arvalid;
    logic [N*AW-1:0] m_araddr;
    logic [N*4-1:0]  m_arlen;
    logic [N-1:0]  m_arready;
    logic [N-1:0]  m_rvalid;
    logic          m_rlast;
    logic [DW-1:0] m_rdata;
    logic [N-1:0]  m_rready;
    logic          ARVALID;
    logic          ARREADY;
    logic [3:0]    ARID;
    logic [3:0]    ARLEN;
    logic [AW-1:0] ARADDR;
    logic          RVALID;
    logic          RREADY;
    logic          RLAST;
    logic [3:0]    RID;
    logic [DW-1:0] RDATA;
    logic          busy;
    logic [1:0]    owner;
    logic          err;

    int n_chk  = 0;
    int n_fail = 0;
    int age [N];

    axi_read_scheduler #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
        .m_rdata(m_rdata), .m_rready(m_rready),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN),
        .ARADDR(ARADDR), .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
        .RID(RID), .RDATA(RDATA), .busy(busy), .owner(owner), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference arbitration: oldest-starved lowest index, else 1 > 0 > 2
    function automatic int pick(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i] && age[i] >= SL) return i;
        if (v[1]) return 1;
        if (v[0]) return 0;
        if (v[2]) return 2;
        return -1;
    endfunction

    // Clock edge plus reference age update
    task automatic adv(input logic [N-1:0] acc);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!m_arvalid[i] || acc[i]) age[i] = 0;
            else if (age[i] < 255)       age[i] = age[i] + 1;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        m_arvalid = '0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        RID       = '0;
        RDATA     = '0;
        m_rready  = '1;
        for (int i = 0; i < N; i++) age[i] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_arready"}, m_arready, 0);
        chk({p, "_rvalid"},  m_rvalid, 0);
        chk({p, "_rlast"},   m_rlast, 0);
        chk({p, "_rdata"},   m_rdata, 0);
        chk({p, "_ARVALID"}, ARVALID, 0);
        chk({p, "_ARADDR"},  ARADDR, 0);
        chk({p, "_ARLEN"},   ARLEN, 0);
        chk({p, "_ARID"},    ARID, 0);
        chk({p, "_RREADY"},  RREADY, 0);
        chk({p, "_busy"},    busy, 0);
        chk({p, "_owner"},   owner, 0);
        chk({p, "_err"},     err, 0);
    endtask

    task automatic set_req(input int m, input logic [AW-1:0] a, input logic [3:0] l);
        m_araddr[m*AW +: AW] = a;
        m_arlen[m*4 +: 4]    = l;
        m_arvalid[m]         = 1'b1;
    endtask

    task automatic grant(output int w);
        @(negedge clk);
        w = pick(m_arvalid);
        chk("arready_onehot", m_arready, 1 << w);
        chk("busy_in_idle", busy, 0);
        chk("arvalid_gap", ARVALID, 0);
        adv(N'(1 << w));
        m_arvalid[w] = 1'b0;
    endtask

    task automatic addr_phase(input int w, input logic [AW-1:0] a,
                              input logic [3:0] l, input int waits);
        ARREADY = 1'b0;
        for (int k = 0; k < waits; k++) begin
            @(negedge clk);
            chk("arvalid_hold", ARVALID, 1);
            chk("araddr_hold", ARADDR, a);
            chk("arlen_hold", ARLEN, l);
            chk("arid_hold", ARID, w);
            adv('0);
        end
        ARREADY = 1'b1;
        @(negedge clk);
        chk("arvalid", ARVALID, 1);
        chk("araddr", ARADDR, a);
        chk("arlen", ARLEN, l);
        chk("arid", ARID, w);
        chk("owner", owner, w);
        chk("busy", busy, 1);
        adv('0);
        ARREADY = 1'b0;
    endtask

    task automatic data_phase(input int w, input logic [3:0] l, input bit jitter);
        logic [DW-1:0] d;
        for (int b = 0; b <= int'(l); b++) begin
            if (jitter && $urandom_range(0, 3) == 0) begin
                RVALID = 1'b0;
                @(negedge clk);
                chk("rvalid_gap", m_rvalid, 0);
                adv('0);
            end
            d      = $urandom;
            RVALID = 1'b1;
            RID    = 4'(w);
            RDATA  = d;
            RLAST  = (b == int'(l));
            if (jitter && $urandom_range(0, 3) == 0) begin
                m_rready[w] = 1'b0;
                @(negedge clk);
                chk("rready_stall", RREADY, 0);
                chk("rvalid_stall", m_rvalid, 1 << w);
                adv('0);
                m_rready[w] = 1'b1;
            end
            @(negedge clk);
            chk("rvalid", m_rvalid, 1 << w);
            chk("rdata", m_rdata, d);
            chk("rlast", m_rlast, (b == int'(l)) ? 1 : 0);
            chk("rready", RREADY, 1);
            adv('0);
        end
        RVALID = 1'b0;
        RLAST  = 1'b0;
    endtask

    task automatic idle_check();
        @(negedge clk);
        chk("busy_after_burst", busy, 0);
        adv('0);
    endtask

    initial begin
        int w;
        int r2;
        int order [3];
        logic [AW-1:0] a [N];
        logic [3:0]    l [N];

        order = '{1, 0, 2};
        m_araddr = '0;
        m_arlen  = '0;
        rst_n    = 1'b0;
        m_arvalid = '0;
        ARREADY  = 1'b0;
        RVALID   = 1'b0;
        RLAST    = 1'b0;
        RID      = '0;
        RDATA    = '0;
        m_rready = '1;
        for (int i = 0; i < N; i++) age[i] = 0;
        #2;
        check_reset_vals("reset");
        do_reset();

        // Single request, ARREADY high
        set_req(0, 32'h100, 4'd3);
        grant(w);
        chk("t1_winner", w, 0);
        addr_phase(0, 32'h100, 4'd3, 0);
        data_phase(0, 4'd3, 1'b0);
        idle_check();

        // Simultaneous requests
        for (int i = 0; i < N; i++) begin
            a[i] = $urandom;
            set_req(i, a[i], 4'd0);
        end
        for (int k = 0; k < 3; k++) begin
            grant(w);
            chk("grant_order", w, order[k]);
            addr_phase(w, a[w], 4'd0, 0);
            data_phase(w, 4'd0, 1'b0);
        end
        idle_check();

        // Starvation: master 1 continuous, master 2 continuous
        set_req(1, 32'h1000, 4'd0);
        set_req(2, 32'h2000, 4'd0);
        r2 = -1;
        for (int r = 0; r < 8 && r2 < 0; r++) begin
            grant(w);
            if (w == 2) r2 = r;
            else m_arvalid[1] = 1'b1;
            addr_phase(w, (w == 2) ? 32'h2000 : 32'h1000, 4'd0, 0);
            data_phase(w, 4'd0, 1'b0);
        end
        chk("starve_round", r2, 3);
        grant(w);
        chk("after_starve", w, 1);
        addr_phase(1, 32'h1000, 4'd0, 0);
        data_phase(1, 4'd0, 1'b0);
        idle_check();

        // ARREADY low for 5 cycles
        set_req(2, 32'hABCD0000, 4'd5);
        grant(w);
        addr_phase(2, 32'hABCD0000, 4'd5, 5);
        data_phase(2, 4'd5, 1'b1);
        idle_check();
        chk("err_clean", err, 0);

        // Wrong RID is dropped
        set_req(0, 32'h200, 4'd0);
        grant(w);
        addr_phase(0, 32'h200, 4'd0, 0);
        RVALID = 1'b1; RID = 4'd2; RLAST = 1'b1; RDATA = 32'h5555;
        @(negedge clk);
        chk("badrid_rvalid", m_rvalid, 0);
        chk("badrid_rready", RREADY, 1);
        adv('0);
        RID = 4'd0; RDATA = 32'h6666;
        @(negedge clk);
        chk("badrid_err", err, 1);
        chk("badrid_next_rvalid", m_rvalid, 1);
        chk("badrid_next_rdata", m_rdata, 32'h6666);
        adv('0);
        RVALID = 1'b0; RLAST = 1'b0;
        idle_check();

        // RVALID while idle
        do_reset();
        RVALID = 1'b1; RID = 4'd0;
        @(negedge clk);
        chk("idle_rvalid_rready", RREADY, 0);
        chk("idle_rvalid_mrvalid", m_rvalid, 0);
        adv('0);
        RVALID = 1'b0;
        @(negedge clk);
        chk("idle_rvalid_err", err, 1);
        adv('0);

        // Early RLAST on beat 1 of a len-3 burst
        do_reset();
        set_req(0, 32'h300, 4'd3);
        grant(w);
        addr_phase(0, 32'h300, 4'd3, 0);
        RVALID = 1'b1; RID = 4'd0; RLAST = 1'b0; RDATA = 32'h11;
        @(negedge clk);
        chk("early_b0", m_rvalid, 1);
        adv('0);
        RLAST = 1'b1; RDATA = 32'h22;
        @(negedge clk);
        chk("early_b1_rlast", m_rlast, 1);
        chk("early_err_before", err, 0);
        adv('0);
        RVALID = 1'b0; RLAST = 1'b0;
        @(negedge clk);
        chk("early_busy", busy, 0);
        chk("early_err", err, 1);
        adv('0);

        // Missing RLAST at the final counted beat
        do_reset();
        set_req(1, 32'h40, 4'd0);
        grant(w);
        addr_phase(1, 32'h40, 4'd0, 0);
        RVALID = 1'b1; RID = 4'd1; RLAST = 1'b0; RDATA = 32'h77;
        @(negedge clk);
        chk("norlast_rvalid", m_rvalid, 3'b010);
        adv('0);
        RVALID = 1'b0;
        @(negedge clk);
        chk("norlast_busy", busy, 1);
        chk("norlast_err", err, 1);
        adv('0);
        RVALID = 1'b1; RLAST = 1'b1; RDATA = 32'h88;
        @(negedge clk);
        chk("norlast_final", m_rvalid, 3'b010);
        adv('0);
        RVALID = 1'b0; RLAST = 1'b0;
        idle_check();

        // Asynchronous reset during DATA
        set_req(2, 32'h500, 4'd3);
        grant(w);
        addr_phase(2, 32'h500, 4'd3, 0);
        RVALID = 1'b1; RID = 4'd2; RDATA = 32'hDEADBEEF;
        @(negedge clk);
        chk("midrst_pre", m_rvalid, 3'b100);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        do_reset();

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = $urandom;
                l[i] = 4'($urandom_range(0, 7));
                m_araddr[i*AW +: AW] = a[i];
                m_arlen[i*4 +: 4]    = l[i];
            end
            m_arvalid = N'($urandom_range(1, 7));
            while (m_arvalid != '0) begin
                if ($urandom_range(0, 5) == 0)
                    m_arvalid[$urandom_range(0, 2)] = 1'b0;
                if (m_arvalid == '0) break;
                grant(w);
                addr_phase(w, a[w], l[w], $urandom_range(0, 2));
                data_phase(w, l[w], 1'b1);
            end
            idle_check();
        end
        chk("final_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
